// File: rtl/uart_sim_pkg.sv
// Shared types and helpers for the clocked UART simulation model.
// Covers the parity mode encoding, both FSM state sets and the parity bit calculation.
package uart_sim_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Parity bit that accompanies a data word. Narrower words are zero-extended,
  // which does not change the XOR reduction.
  function automatic logic calc_parity(input logic [7:0] data, input parity_e mode);
    case (mode)
      EVEN:    return ^data;
      ODD:     return ~(^data);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sim_clocked_if.sv
// Byte-stream side of the UART model: the RX valid/ready output stream and
// the TX valid/ready input stream. Signal names follow the model's own view
// (_o driven by the model, _i driven by its user).
interface uart_sim_clocked_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_parity_err_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic                 rx_frame_err_o;
  logic                 rx_overflow_o;
  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;

  // Used by whoever consumes RX bytes and supplies TX bytes.
  modport master (
    input  rx_data_o, rx_parity_err_o, rx_valid_o, rx_frame_err_o, rx_overflow_o, tx_ready_o,
    output rx_ready_i, tx_data_i, tx_valid_i
  );

  // Used by the UART model itself.
  modport slave (
    output rx_data_o, rx_parity_err_o, rx_valid_o, rx_frame_err_o, rx_overflow_o, tx_ready_o,
    input  rx_ready_i, tx_data_i, tx_valid_i
  );

endinterface

// File: rtl/uart_sim_rx_fifo.sv
// RX byte buffer: WIDTH bits wide, DEPTH entries (power of two).
// A push while full is dropped; a pop while empty is ignored.
module uart_sim_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  assign empty_o    = (wrPtr_q == rdPtr_q);
  assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPush     = push_i && !full_o;
  assign doPop      = pop_i && !empty_o;
  assign pop_data_o = mem_q[rdPtr_q[AW-1:0]];

  // Storage array; contents need no reset because empty_o gates their use.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= push_data_i;
  end

  // Read/write pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_sim_clocked.sv
// Clock-driven full-duplex UART model for testbenches.
// RX: 2-flop synchroniser, mid-bit sampling FSM, buffered byte stream with
// parity/frame/overflow reporting. TX: valid/ready byte in, serial frame out.
// Optional macro UART_SIM_CONSOLE_EN echoes received bytes to the console.
module uart_sim_clocked
  import uart_sim_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  input  logic rx_en_i,
  output logic tx_o,
  uart_sim_clocked_if.slave uartBus
);

  localparam int             TW        = $clog2(CLKS_PER_BIT);
  localparam int             BW        = $clog2(DATA_BITS);
  localparam logic [TW-1:0]  BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam parity_e        PMODE     = (PARITY == 1) ? EVEN : ((PARITY == 2) ? ODD : NONE);
  localparam bit             HAS_PAR   = (PARITY != 0);

  logic                 rxSync1_q, rxSync2_q, rxPrev_q;
  rx_state_e            rxState_q;
  logic [TW-1:0]        rxTimer_q;
  logic [BW-1:0]        rxBitIdx_q;
  logic                 rxStopIdx_q, rxStopBad_q;
  logic [DATA_BITS-1:0] rxShift_q;
  logic                 rxPerr_q, pushStrobe_q, frameErr_q, overflow_q;
  logic [DATA_BITS:0]   fifoHead;
  logic                 fifoFull, fifoEmpty;

  tx_state_e            txState_q;
  logic [TW-1:0]        txTimer_q;
  logic [BW-1:0]        txBitIdx_q;
  logic                 txStopIdx_q;
  logic [DATA_BITS-1:0] txShift_q;
  logic                 txParity_q, tx_q, txReady_q;

  // Bring the asynchronous line into the clock domain and keep the previous value for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
      rxPrev_q  <= 1'b1;
    end else begin
      rxSync1_q <= rx_i;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
    end
  end

  // RX frame FSM: half-bit start check, then one mid-bit sample per bit; pushes or flags at the last stop sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxState_q    <= RX_IDLE;
      rxTimer_q    <= '0;
      rxBitIdx_q   <= '0;
      rxStopIdx_q  <= 1'b0;
      rxStopBad_q  <= 1'b0;
      rxShift_q    <= '0;
      rxPerr_q     <= 1'b0;
      pushStrobe_q <= 1'b0;
      frameErr_q   <= 1'b0;
    end else begin
      pushStrobe_q <= 1'b0;
      frameErr_q   <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          if (rx_en_i && rxPrev_q && !rxSync2_q) begin
            rxState_q <= RX_START;
            rxTimer_q <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (rxTimer_q != '0) begin
            rxTimer_q <= rxTimer_q - 1'b1;
          end else if (rxSync2_q) begin
            rxState_q <= RX_IDLE;
            rxTimer_q <= '0;
          end else begin
            rxState_q  <= RX_DATA;
            rxTimer_q  <= BIT_LOAD;
            rxBitIdx_q <= '0;
            rxPerr_q   <= 1'b0;
          end
        end
        RX_DATA: begin
          if (rxTimer_q != '0) begin
            rxTimer_q <= rxTimer_q - 1'b1;
          end else begin
            rxShift_q <= {rxSync2_q, rxShift_q[DATA_BITS-1:1]};
            rxTimer_q <= BIT_LOAD;
            if (rxBitIdx_q == LAST_BIT) begin
              rxState_q   <= HAS_PAR ? RX_PARITY : RX_STOP;
              rxStopIdx_q <= 1'b0;
              rxStopBad_q <= 1'b0;
            end else begin
              rxBitIdx_q <= rxBitIdx_q + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (rxTimer_q != '0) begin
            rxTimer_q <= rxTimer_q - 1'b1;
          end else begin
            rxPerr_q    <= rxSync2_q ^ calc_parity(8'(rxShift_q), PMODE);
            rxState_q   <= RX_STOP;
            rxTimer_q   <= BIT_LOAD;
            rxStopIdx_q <= 1'b0;
            rxStopBad_q <= 1'b0;
          end
        end
        RX_STOP: begin
          if (rxTimer_q != '0) begin
            rxTimer_q <= rxTimer_q - 1'b1;
          end else if (rxStopIdx_q == LAST_STOP) begin
            rxState_q <= RX_IDLE;
            rxTimer_q <= '0;
            if (rxStopBad_q || !rxSync2_q) frameErr_q   <= 1'b1;
            else                           pushStrobe_q <= 1'b1;
          end else begin
            rxStopIdx_q <= 1'b1;
            rxStopBad_q <= rxStopBad_q || !rxSync2_q;
            rxTimer_q   <= BIT_LOAD;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

  uart_sim_rx_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_rxFifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (pushStrobe_q),
    .push_data_i ({rxPerr_q, rxShift_q}),
    .pop_i       (uartBus.rx_ready_i),
    .pop_data_o  (fifoHead),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  // Sticky overflow: any push that finds the buffer full loses its byte.
  always_ff @(posedge clk_i) begin
    if (rst_i)                          overflow_q <= 1'b0;
    else if (pushStrobe_q && fifoFull)  overflow_q <= 1'b1;
  end

  assign uartBus.rx_data_o       = fifoHead[DATA_BITS-1:0];
  assign uartBus.rx_parity_err_o = fifoHead[DATA_BITS];
  assign uartBus.rx_valid_o      = !fifoEmpty;
  assign uartBus.rx_frame_err_o  = frameErr_q;
  assign uartBus.rx_overflow_o   = overflow_q;

  // TX frame FSM: each state holds its line level for a full bit time; ready only while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txState_q   <= TX_IDLE;
      txTimer_q   <= '0;
      txBitIdx_q  <= '0;
      txStopIdx_q <= 1'b0;
      txShift_q   <= '0;
      txParity_q  <= 1'b0;
      tx_q        <= 1'b1;
      txReady_q   <= 1'b0;
    end else begin
      case (txState_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (uartBus.tx_valid_i && txReady_q) begin
            txShift_q  <= uartBus.tx_data_i;
            txParity_q <= calc_parity(8'(uartBus.tx_data_i), PMODE);
            txReady_q  <= 1'b0;
            tx_q       <= 1'b0;
            txTimer_q  <= BIT_LOAD;
            txState_q  <= TX_START;
          end else begin
            txReady_q <= 1'b1;
          end
        end
        TX_START: begin
          if (txTimer_q != '0) begin
            txTimer_q <= txTimer_q - 1'b1;
          end else begin
            txState_q  <= TX_DATA;
            txTimer_q  <= BIT_LOAD;
            txBitIdx_q <= '0;
            tx_q       <= txShift_q[0];
            txShift_q  <= txShift_q >> 1;
          end
        end
        TX_DATA: begin
          if (txTimer_q != '0) begin
            txTimer_q <= txTimer_q - 1'b1;
          end else begin
            txTimer_q <= BIT_LOAD;
            if (txBitIdx_q == LAST_BIT) begin
              txStopIdx_q <= 1'b0;
              if (HAS_PAR) begin
                txState_q <= TX_PARITY;
                tx_q      <= txParity_q;
              end else begin
                txState_q <= TX_STOP;
                tx_q      <= 1'b1;
              end
            end else begin
              txBitIdx_q <= txBitIdx_q + 1'b1;
              tx_q       <= txShift_q[0];
              txShift_q  <= txShift_q >> 1;
            end
          end
        end
        TX_PARITY: begin
          if (txTimer_q != '0) begin
            txTimer_q <= txTimer_q - 1'b1;
          end else begin
            txState_q   <= TX_STOP;
            txTimer_q   <= BIT_LOAD;
            txStopIdx_q <= 1'b0;
            tx_q        <= 1'b1;
          end
        end
        TX_STOP: begin
          if (txTimer_q != '0) begin
            txTimer_q <= txTimer_q - 1'b1;
          end else if (txStopIdx_q == LAST_STOP) begin
            txState_q <= TX_IDLE;
            txTimer_q <= '0;
            txReady_q <= 1'b1;
          end else begin
            txStopIdx_q <= 1'b1;
            txTimer_q   <= BIT_LOAD;
          end
        end
        default: txState_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_o               = tx_q;
  assign uartBus.tx_ready_o = txReady_q;

`ifdef UART_SIM_CONSOLE_EN
  logic consoleLineStart_q;

  // Console echo of received traffic; a newline byte makes the next byte start a fresh prefixed line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      consoleLineStart_q <= 1'b1;
    end else begin
      if (pushStrobe_q) begin
        if (consoleLineStart_q) $write("[UART]: ");
        $write("%c", 8'(rxShift_q));
        consoleLineStart_q <= (8'(rxShift_q) == 8'h0A);
        if (rxPerr_q) $display("[UART] parity error");
      end
      if (frameErr_q) $display("[UART] frame error");
    end
  end
`endif

endmodule

// File: tb/tb_uart_sim_clocked.sv
// Directed bench for uart_sim_clocked: instance A (8 data bits, even parity,
// 1 stop) covers loopback, parity/frame errors, overflow, glitch, rx_en and
// mid-frame reset; instance B (7 data bits, odd parity, 2 stops) covers loopback.
module tb_uart_sim_clocked;

  localparam int CPB     = 16;
  localparam int FRAME_A = (1 + 8 + 1 + 1) * CPB;
  localparam int FRAME_B = (1 + 7 + 1 + 2) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxDrive = 1'b1;
  logic loopA = 1'b0;
  logic rxEnA = 1'b1;
  logic rxA, txA, txB;

  int vecCount  = 0;
  int missCount = 0;
  int frameErrA = 0;

  uart_sim_clocked_if #(.DATA_BITS(8)) busA ();
  uart_sim_clocked_if #(.DATA_BITS(7)) busB ();

  assign rxA = loopA ? txA : rxDrive;

  uart_sim_clocked #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .rx_i(rxA), .rx_en_i(rxEnA), .tx_o(txA), .uartBus(busA.slave)
  );

  uart_sim_clocked #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dutB (
    .clk_i(clk), .rst_i(rst), .rx_i(txB), .rx_en_i(1'b1), .tx_o(txB), .uartBus(busB.slave)
  );

  initial forever #5 clk = ~clk;

  // Count every cycle the frame-error pulse is high on instance A.
  always @(posedge clk) begin
    if (busA.rx_frame_err_o) frameErrA++;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic txReady(input bit useB);
    return useB ? busB.tx_ready_o : busA.tx_ready_o;
  endfunction

  function automatic logic rxValid(input bit useB);
    return useB ? busB.rx_valid_o : busA.rx_valid_o;
  endfunction

  // Hand one byte to the TX side and measure cycles until tx_ready returns.
  task automatic applyStimulus(input bit useB, input logic [7:0] data, output int cycles);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!txReady(useB) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (useB) begin
      busB.tx_data_i  = data[6:0];
      busB.tx_valid_i = 1'b1;
    end else begin
      busA.tx_data_i  = data;
      busA.tx_valid_i = 1'b1;
    end
    @(posedge clk);
    #1;
    busA.tx_valid_i = 1'b0;
    busB.tx_valid_i = 1'b0;
    checkOutput(useB ? "txStartB" : "txStartA", 32'(useB ? txB : txA), 32'd0);
    cycles = 0;
    while (!txReady(useB) && cycles < 1000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic waitRxValid(input bit useB, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rxValid(useB)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic popRx(input bit useB);
    @(negedge clk);
    if (useB) busB.rx_ready_i = 1'b1;
    else      busA.rx_ready_i = 1'b1;
    @(posedge clk);
    #1;
    busA.rx_ready_i = 1'b0;
    busB.rx_ready_i = 1'b0;
  endtask

  // Drive one 8-bit frame onto instance A's RX line with explicit parity and stop levels.
  task automatic driveFrame(input logic [7:0] data, input logic parityBit, input logic stopBit);
    @(negedge clk);
    rxDrive = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxDrive = data[i];
      repeat (CPB) @(negedge clk);
    end
    rxDrive = parityBit;
    repeat (CPB) @(negedge clk);
    rxDrive = stopBit;
    repeat (CPB) @(negedge clk);
    rxDrive = 1'b1;
  endtask

  initial begin
    int cyc;
    int errBefore;
    bit seen;
    logic [7:0] b;

    busA.rx_ready_i = 1'b0; busA.tx_valid_i = 1'b0; busA.tx_data_i = '0;
    busB.rx_ready_i = 1'b0; busB.tx_valid_i = 1'b0; busB.tx_data_i = '0;

    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("rstTxA", 32'(txA), 32'd1);
    checkOutput("rstReadyA", 32'(busA.tx_ready_o), 32'd0);
    checkOutput("rstValidA", 32'(busA.rx_valid_o), 32'd0);
    checkOutput("rstFrameErrA", 32'(busA.rx_frame_err_o), 32'd0);
    checkOutput("rstOverflowA", 32'(busA.rx_overflow_o), 32'd0);
    checkOutput("rstTxB", 32'(txB), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("readyAfterRstA", 32'(busA.tx_ready_o), 32'd1);

    // Loopback 0x55 then 0xA3
    loopA = 1'b1;
    applyStimulus(1'b0, 8'h55, cyc);
    checkOutput("frameLenA55", 32'(cyc), 32'(FRAME_A));
    waitRxValid(1'b0, seen);
    checkOutput("loopValid55", 32'(seen), 32'd1);
    checkOutput("loopData55", 32'(busA.rx_data_o), 32'h55);
    checkOutput("loopPerr55", 32'(busA.rx_parity_err_o), 32'd0);
    popRx(1'b0);
    @(negedge clk);
    checkOutput("emptyAfterPop", 32'(busA.rx_valid_o), 32'd0);
    applyStimulus(1'b0, 8'hA3, cyc);
    checkOutput("frameLenAA3", 32'(cyc), 32'(FRAME_A));
    waitRxValid(1'b0, seen);
    checkOutput("loopValidA3", 32'(seen), 32'd1);
    checkOutput("loopDataA3", 32'(busA.rx_data_o), 32'hA3);
    checkOutput("loopPerrA3", 32'(busA.rx_parity_err_o), 32'd0);
    popRx(1'b0);
    checkOutput("loopNoFrameErr", 32'(frameErrA), 32'd0);
    loopA = 1'b0;
    repeat (20) @(negedge clk);

    // Wrong parity: 0x41 has even parity bit 0, drive 1
    driveFrame(8'h41, 1'b1, 1'b1);
    waitRxValid(1'b0, seen);
    checkOutput("perrValid", 32'(seen), 32'd1);
    checkOutput("perrData", 32'(busA.rx_data_o), 32'h41);
    checkOutput("perrFlag", 32'(busA.rx_parity_err_o), 32'd1);
    popRx(1'b0);

    // Stop bit low: 0x7E dropped with a single-cycle frame error
    errBefore = frameErrA;
    driveFrame(8'h7E, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("frameErrPulses", 32'(frameErrA - errBefore), 32'd1);
    checkOutput("frameErrNoPush", 32'(busA.rx_valid_o), 32'd0);

    // Overflow: 17 frames into a 16-entry buffer without popping
    for (int i = 0; i < 17; i++) begin
      b = 8'(i + 1);
      driveFrame(b, ^b, 1'b1);
    end
    repeat (20) @(negedge clk);
    checkOutput("ovfFlag", 32'(busA.rx_overflow_o), 32'd1);
    checkOutput("ovfValid", 32'(busA.rx_valid_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput("ovfData", 32'(busA.rx_data_o), 32'(i + 1));
      popRx(1'b0);
    end
    @(negedge clk);
    checkOutput("ovfDrained", 32'(busA.rx_valid_o), 32'd0);
    checkOutput("ovfSticky", 32'(busA.rx_overflow_o), 32'd1);

    // Short low glitch in idle
    errBefore = frameErrA;
    rxDrive = 1'b0;
    repeat (4) @(negedge clk);
    rxDrive = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitchNoPush", 32'(busA.rx_valid_o), 32'd0);
    checkOutput("glitchNoErr", 32'(frameErrA - errBefore), 32'd0);

    // Receiver disabled: a valid frame is ignored
    rxEnA = 1'b0;
    repeat (2) @(negedge clk);
    driveFrame(8'h5A, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("rxDisabled", 32'(busA.rx_valid_o), 32'd0);
    rxEnA = 1'b1;
    repeat (4) @(negedge clk);
    driveFrame(8'h3C, 1'b0, 1'b1);
    waitRxValid(1'b0, seen);
    checkOutput("reenValid", 32'(seen), 32'd1);
    checkOutput("reenData", 32'(busA.rx_data_o), 32'h3C);
    popRx(1'b0);

    // Reset during data bit 3 of 0xF7 (bit 3 is 0)
    @(negedge clk);
    busA.tx_data_i  = 8'hF7;
    busA.tx_valid_i = 1'b1;
    @(posedge clk);
    #1;
    busA.tx_valid_i = 1'b0;
    repeat (70) @(posedge clk);
    @(negedge clk);
    checkOutput("midTxBit3", 32'(txA), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstMidTxLine", 32'(txA), 32'd1);
    checkOutput("rstMidTxReady", 32'(busA.tx_ready_o), 32'd0);
    @(negedge clk);
    checkOutput("rstClearsOvf", 32'(busA.rx_overflow_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("readyAfterMidRst", 32'(busA.tx_ready_o), 32'd1);

    // Instance B loopback: 7 data bits, odd parity, 2 stop bits
    applyStimulus(1'b1, 8'h55, cyc);
    checkOutput("frameLenB55", 32'(cyc), 32'(FRAME_B));
    waitRxValid(1'b1, seen);
    checkOutput("loopValidB55", 32'(seen), 32'd1);
    checkOutput("loopDataB55", 32'(busB.rx_data_o), 32'h55);
    checkOutput("loopPerrB55", 32'(busB.rx_parity_err_o), 32'd0);
    popRx(1'b1);
    applyStimulus(1'b1, 8'h23, cyc);
    checkOutput("frameLenB23", 32'(cyc), 32'(FRAME_B));
    waitRxValid(1'b1, seen);
    checkOutput("loopDataB23", 32'(busB.rx_data_o), 32'h23);
    checkOutput("loopPerrB23", 32'(busB.rx_parity_err_o), 32'd0);
    popRx(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
